// File: rtl/fcvt_int_fp.sv
// Integer-to-floating-point converter (32/64-bit source, single/double result).
// The magnitude is normalised one bit per cycle, then rounded once.
module fcvt_int_fp (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic [63:0] rs1_i,
  input  logic        long_i,
  input  logic        unsigned_i,
  input  logic        fmt_i,
  input  logic [2:0]  rm_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] fcvtOut_o,
  output logic [4:0]  fflags_o
);

  typedef enum logic [2:0] {IDLE, LOAD, NORM, ROUND, DONE} state_t;

  state_t      state_reg;
  logic [63:0] src_reg;
  logic        long_reg;
  logic        unsigned_reg;
  logic        fmt_reg;
  logic [2:0]  rm_reg;
  logic        sign_reg;
  logic [63:0] mag_reg;
  logic [6:0]  exp_reg;

  logic        load_sign;
  logic [63:0] src_ext;
  logic [63:0] abs_val;
  logic [63:0] load_mag;
  logic [6:0]  load_exp;

  always_comb begin
    load_sign = ~unsigned_reg & (long_reg ? src_reg[63] : src_reg[31]);
    if (long_reg)
      src_ext = src_reg;
    else if (unsigned_reg)
      src_ext = {32'b0, src_reg[31:0]};
    else
      src_ext = {{32{src_reg[31]}}, src_reg[31:0]};
    abs_val  = load_sign ? (~src_ext + 64'd1) : src_ext;
    // 32-bit sources sit in the upper half so both widths share one datapath
    load_mag = long_reg ? abs_val : {abs_val[31:0], 32'b0};
    load_exp = long_reg ? 7'd63 : 7'd31;
  end

  logic        guard;
  logic        sticky;
  logic        lsb;
  logic        inc;
  logic [23:0] sp_fsum;
  logic [52:0] dp_fsum;
  logic        carry;
  logic [7:0]  exp_r;
  logic [7:0]  sp_bexp;
  logic [10:0] dp_bexp;
  logic [63:0] sp_res;
  logic [63:0] dp_res;

  always_comb begin
    guard  = fmt_reg ? mag_reg[10] : mag_reg[39];
    sticky = fmt_reg ? (|mag_reg[9:0]) : (|mag_reg[38:0]);
    lsb    = fmt_reg ? mag_reg[11] : mag_reg[40];
    case (rm_reg)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sign_reg & (guard | sticky);
      3'b011:  inc = ~sign_reg & (guard | sticky);
      3'b100:  inc = guard;
      default: inc = guard & (sticky | lsb);
    endcase
    // hidden bit is always 1 here, so a fraction carry-out is the significand carry-out
    sp_fsum = {1'b0, mag_reg[62:40]} + {23'b0, inc};
    dp_fsum = {1'b0, mag_reg[62:11]} + {52'b0, inc};
    carry   = fmt_reg ? dp_fsum[52] : sp_fsum[23];
    exp_r   = {1'b0, exp_reg} + {7'b0, carry};
    sp_bexp = exp_r + 8'd127;
    dp_bexp = {3'b0, exp_r} + 11'd1023;
    sp_res  = {32'hFFFFFFFF, sign_reg, sp_bexp, carry ? 23'b0 : sp_fsum[22:0]};
    dp_res  = {sign_reg, dp_bexp, carry ? 52'b0 : dp_fsum[51:0]};
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_reg    <= IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      fcvtOut_o    <= 64'b0;
      fflags_o     <= 5'b0;
      src_reg      <= 64'b0;
      long_reg     <= 1'b0;
      unsigned_reg <= 1'b0;
      fmt_reg      <= 1'b0;
      rm_reg       <= 3'b0;
      sign_reg     <= 1'b0;
      mag_reg      <= 64'b0;
      exp_reg      <= 7'b0;
    end else begin
      done_o <= 1'b0;
      if (state_reg != IDLE && kill_i) begin
        state_reg <= IDLE;
        busy_o    <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start_i) begin
              src_reg      <= rs1_i;
              long_reg     <= long_i;
              unsigned_reg <= unsigned_i;
              fmt_reg      <= fmt_i;
              rm_reg       <= rm_i;
              busy_o       <= 1'b1;
              state_reg    <= LOAD;
            end
          end
          LOAD: begin
            sign_reg <= load_sign;
            mag_reg  <= load_mag;
            exp_reg  <= load_exp;
            if (load_mag == 64'b0) begin
              fcvtOut_o <= 64'b0;
              fflags_o  <= 5'b0;
              done_o    <= 1'b1;
              state_reg <= DONE;
            end else begin
              state_reg <= NORM;
            end
          end
          NORM: begin
            if (mag_reg[63]) begin
              state_reg <= ROUND;
            end else begin
              mag_reg <= {mag_reg[62:0], 1'b0};
              exp_reg <= exp_reg - 7'd1;
            end
          end
          ROUND: begin
            fcvtOut_o <= fmt_reg ? dp_res : sp_res;
            fflags_o  <= {4'b0, guard | sticky};
            done_o    <= 1'b1;
            state_reg <= DONE;
          end
          DONE: begin
            busy_o    <= 1'b0;
            state_reg <= IDLE;
          end
          default: begin
            busy_o    <= 1'b0;
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fcvt_int_fp.sv
// Directed bench for fcvt_int_fp: an exact-arithmetic rounding model predicts
// result, flags and latency; a negedge process checks every done strobe.
module tb_fcvt_int_fp;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic        start_i;
  logic        kill_i;
  logic [63:0] rs1_i;
  logic        long_i;
  logic        unsigned_i;
  logic        fmt_i;
  logic [2:0]  rm_i;
  logic        busy_o;
  logic        done_o;
  logic [63:0] fcvtOut_o;
  logic [4:0]  fflags_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [63:0] exp_out = 64'b0;
  logic [4:0]  exp_flags = 5'b0;
  bit          expect_done = 1'b0;

  fcvt_int_fp dut (
    .clk_i      (clk_i),
    .resetn_i   (resetn_i),
    .start_i    (start_i),
    .kill_i     (kill_i),
    .rs1_i      (rs1_i),
    .long_i     (long_i),
    .unsigned_i (unsigned_i),
    .fmt_i      (fmt_i),
    .rm_i       (rm_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .fcvtOut_o  (fcvtOut_o),
    .fflags_o   (fflags_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Reference: find the leading one, keep P significant bits, and round the
  // discarded remainder against exactly one half ulp.
  function automatic void model(input logic [63:0] rs1, input logic lng, input logic uns,
                                input logic fmt, input logic [2:0] rm,
                                output logic [63:0] res, output logic [4:0] fl, output int lat);
    logic        sgn;
    logic [63:0] m;
    logic [31:0] w;
    logic [63:0] q, rem, half;
    logic        up, inexact;
    int          p, prec, shift;
    if (lng) begin
      sgn = !uns && rs1[63];
      m = sgn ? (64'd0 - rs1) : rs1;
    end else begin
      w = rs1[31:0];
      sgn = !uns && w[31];
      if (sgn) w = 32'd0 - w;
      m = {32'b0, w};
    end
    if (m == 64'd0) begin
      res = 64'b0; fl = 5'b0; lat = 1;
      return;
    end
    p = 63;
    while (!m[p]) p--;
    lat = 3 + (lng ? (63 - p) : (31 - p));
    prec = fmt ? 53 : 24;
    inexact = 1'b0;
    if (p <= prec - 1) begin
      q = m << (prec - 1 - p);
    end else begin
      shift = p - (prec - 1);
      q = m >> shift;
      rem = m & ((64'd1 << shift) - 64'd1);
      half = 64'd1 << (shift - 1);
      inexact = (rem != 64'd0);
      case (rm)
        3'd1:    up = 1'b0;
        3'd2:    up = sgn && inexact;
        3'd3:    up = !sgn && inexact;
        3'd4:    up = (rem >= half);
        default: up = (rem > half) || (rem == half && q[0]);
      endcase
      q = q + {63'b0, up};
      if (q == (64'd1 << prec)) begin
        q = q >> 1;
        p++;
      end
    end
    if (fmt) res = {sgn, 11'(p + 1023), q[51:0]};
    else     res = {32'hFFFFFFFF, sgn, 8'(p + 127), q[22:0]};
    fl = {4'b0, inexact};
  endfunction

  always @(negedge clk_i) begin
    if (resetn_i && done_o) begin
      if (!expect_done) begin
        total_cnt++;
        $display("FAIL unexpected_done: got done_o=1 expected 0");
      end else begin
        check("result", fcvtOut_o, exp_out);
        check("fflags", {59'b0, fflags_o}, {59'b0, exp_flags});
      end
    end
  end

  task automatic run(input logic [63:0] rs1, input logic lng, input logic uns,
                     input logic fmt, input logic [2:0] rm, input bit pulse,
                     input string name);
    int lat_exp, cnt;
    model(rs1, lng, uns, fmt, rm, exp_out, exp_flags, lat_exp);
    @(negedge clk_i);
    rs1_i = rs1; long_i = lng; unsigned_i = uns; fmt_i = fmt; rm_i = rm;
    start_i = 1'b1;
    expect_done = 1'b1;
    @(negedge clk_i);
    if (pulse) begin
      rs1_i = ~rs1; fmt_i = ~fmt; rm_i = 3'd3;
    end else begin
      start_i = 1'b0;
    end
    check({name, "_busy"}, {63'b0, busy_o}, 64'd1);
    cnt = 0;
    while (!done_o && cnt < 200) begin
      @(negedge clk_i);
      cnt++;
      if (pulse && cnt == 3) begin
        start_i = 1'b1; rs1_i = 64'h5555;
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    check({name, "_latency"}, 64'(cnt), 64'(lat_exp));
    @(negedge clk_i);
    expect_done = 1'b0;
    check({name, "_done_pulse"}, {62'b0, done_o, busy_o}, 64'd0);
    $display("conv %s rs1=%h long=%0d uns=%0d fmt=%0d rm=%0d -> %h flags=%h lat=%0d",
             name, rs1, lng, uns, fmt, rm, fcvtOut_o, fflags_o, cnt);
  endtask

  logic [63:0] prev_out;
  logic [4:0]  prev_flags;

  initial begin
    resetn_i = 1'b0; start_i = 1'b0; kill_i = 1'b0;
    rs1_i = 64'b0; long_i = 1'b0; unsigned_i = 1'b0; fmt_i = 1'b0; rm_i = 3'b0;
    #1;
    check("reset_state", {busy_o, done_o, fflags_o}, 64'd0);
    check("reset_out", fcvtOut_o, 64'd0);
    repeat (2) @(negedge clk_i);
    resetn_i = 1'b1;

    run(64'd1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "w_one_sp");
    check("lit_one_sp", fcvtOut_o, 64'hFFFFFFFF3F800000);
    run(64'h00000000FFFFFFFF, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "w_m1_dp");
    check("lit_m1_dp", fcvtOut_o, 64'hBFF0000000000000);
    run(64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, "lu_max_rne");
    check("lit_lumax_rne", {fflags_o, fcvtOut_o[58:0]}, {5'd1, 59'h3F0000000000000});
    check("lit_lumax_rne_top", 64'(fcvtOut_o[63:59]), 64'h8);
    run(64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, "lu_max_rtz");
    check("lit_lumax_rtz", fcvtOut_o, 64'h43EFFFFFFFFFFFFF);
    run(64'h01000001, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "w_tie_rne");
    check("lit_tie_rne", fcvtOut_o, 64'hFFFFFFFF4B800000);
    run(64'h01000001, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, "w_tie_rup");
    check("lit_tie_rup", fcvtOut_o, 64'hFFFFFFFF4B800001);
    check("lit_tie_rup_nx", 64'(fflags_o), 64'd1);

    run(64'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, "zero_sp_pulse");
    check("lit_zero", fcvtOut_o, 64'd0);
    run(64'hFFFFFFFF00000000, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, "zero_hi_w");
    run(64'd7, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, "busy_pulse");
    run(64'h8000000000000000, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, "l_min_dp");
    check("lit_l_min_dp", fcvtOut_o, 64'hC3E0000000000000);
    run(64'h80000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "w_min_sp");
    run(64'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, "wu_max_sp");
    run(64'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, "wu_max_sp_rtz");
    run(64'hFFFFFFFF_FFFFFF01, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, "l_neg_rdn");
    run(64'h00000000_0100000B, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, "w_rmm");
    run(64'h00000000_01000003, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, "w_rm5");
    run(64'h00000000_01000003, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, "w_rdn_pos");
    run(64'h0123456789ABCDEF, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, "l_dp_rup");
    run(64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "l_max_sp");

    // kill mid-NORM: no strobe, previous result must survive
    prev_out = fcvtOut_o;
    prev_flags = fflags_o;
    @(negedge clk_i);
    rs1_i = 64'd1; long_i = 1'b0; unsigned_i = 1'b0; fmt_i = 1'b1; rm_i = 3'd0;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    check("kill_idle", {63'b0, busy_o}, 64'd0);
    repeat (40) @(negedge clk_i);
    check("kill_out_kept", fcvtOut_o, prev_out);
    check("kill_flags_kept", 64'(fflags_o), 64'(prev_flags));
    $display("kill mid-NORM: out=%h flags=%h busy=%0d", fcvtOut_o, fflags_o, busy_o);

    // asynchronous reset mid-NORM
    @(negedge clk_i);
    rs1_i = 64'd3; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    #2;
    resetn_i = 1'b0;
    #1;
    check("rst_busy_done", {62'b0, busy_o, done_o}, 64'd0);
    check("rst_out", fcvtOut_o, 64'd0);
    check("rst_flags", 64'(fflags_o), 64'd0);
    $display("reset mid-NORM: out=%h flags=%h busy=%0d", fcvtOut_o, fflags_o, busy_o);
    repeat (2) @(negedge clk_i);
    resetn_i = 1'b1;
    run(64'd1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "after_reset");
    check("lit_after_reset", fcvtOut_o, 64'hFFFFFFFF3F800000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
